mux_rr_pipe: RTL and testbench



---
 rtl/mux_pkg.sv | 24 ++
 rtl/mux_rr_pipe_rr_arbiter.sv | 74 +++++++
 rtl/mux_rr_pipe.sv | 119 +++++++++++
 tb/tb_mux_rr_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the round-robin / fixed-select pipelined mux.
//   clog2      - ceiling log2, used to size channel-index fields
//   MODE_RR    - MODE value selecting round-robin arbitration
//   MODE_FIXED - MODE value selecting the channel named by SEL
package mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Smallest r with 2**r >= value; callers guarantee value >= 2.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_pipe_rr_arbiter.sv
// rr_arbiter: round-robin grant generator holding the search pointer.
//   CLK     - clock
//   RST     - asynchronous active-low reset (pointer returns to channel 0)
//   REQ     - per-channel request vector
//   ADVANCE - pulses when an input transfer happens this cycle
//   LAST    - index of the channel that transferred; pointer moves just past it
//   GRANT   - combinational one-hot (or zero) grant, searching from the pointer
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CH = 4,
    localparam int PW = clog2(CH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [CH-1:0] REQ,
    input  logic          ADVANCE,
    input  logic [PW-1:0] LAST,
    output logic [CH-1:0] GRANT
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [CH-1:0] grant_s;

    // Search ptr, ptr+1, ..., wrapping at CH; first requester found wins.
    always_comb begin
        logic found;
        int   idx;
        grant_s = '0;
        found   = 1'b0;
        for (int k = 0; k < CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= CH) begin
                idx = idx - CH;
            end else begin
                idx = idx;
            end
            if (!found && REQ[PW'(idx)]) begin
                grant_s[PW'(idx)] = 1'b1;
                found             = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    // Pointer moves to the channel after the one just served, wrapping at CH-1
    // so non-power-of-two channel counts never leave the pointer out of range.
    always_comb begin
        ptr_d = ptr_q;
        if (ADVANCE) begin
            if (LAST == PW'(CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = LAST + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign GRANT = grant_s;

endmodule

// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: CH-channel valid/ready multiplexer with one registered output stage.
//   CLK, RST  - clock, asynchronous active-low reset
//   MODE, SEL - 0: round-robin arbitration; 1: fixed channel SEL (SEL >= CH never grants)
//   IN_DATA   - channel i in bits [i*WIDTH +: WIDTH]
//   IN_VALID  - per-channel valid
//   IN_READY  - per-channel ready, one-hot or zero, independent of IN_DATA
//   OUT_DATA  - registered selected word
//   OUT_CH    - registered index of the channel that supplied OUT_DATA
//   OUT_VALID - output register holds a word
//   OUT_READY - consumer accepts the word
module mux_rr_pipe
    import mux_pkg::*;
#(
    parameter  int CH    = 4,
    parameter  int WIDTH = 32,
    localparam int SELW  = clog2(CH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MODE,
    input  logic [SELW-1:0]   SEL,
    input  logic [CH*WIDTH-1:0] IN_DATA,
    input  logic [CH-1:0]     IN_VALID,
    output logic [CH-1:0]     IN_READY,
    output logic [WIDTH-1:0]  OUT_DATA,
    output logic [SELW-1:0]   OUT_CH,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;

    logic [CH-1:0]    rr_grant_s;
    logic [CH-1:0]    fixed_grant_s;
    logic [CH-1:0]    grant_s;
    logic [CH-1:0]    in_ready_s;
    logic             load_ok_s;
    logic             in_xfer_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [SELW-1:0]  grant_idx_s;

    rr_arbiter #(.CH(CH)) u_rr_arbiter (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (IN_VALID),
        .ADVANCE (in_xfer_s),
        .LAST    (grant_idx_s),
        .GRANT   (rr_grant_s)
    );

    // Fixed-select decode: comparing SEL against every in-range index means an
    // out-of-range SEL simply matches nothing.
    always_comb begin
        fixed_grant_s = '0;
        for (int i = 0; i < CH; i++) begin
            fixed_grant_s[i] = IN_VALID[i] & (SEL == SELW'(i));
        end
    end

    // Grant/ready: output register can take a word when empty or draining now.
    always_comb begin
        load_ok_s = ~out_valid_q | OUT_READY;
        if (MODE == MODE_FIXED) begin
            grant_s = fixed_grant_s;
        end else begin
            grant_s = rr_grant_s;
        end
        in_ready_s = grant_s & {CH{load_ok_s}};
        in_xfer_s  = |(in_ready_s & IN_VALID);
    end

    // AND-OR data and index selection keyed by the one-hot grant.
    always_comb begin
        sel_data_s  = '0;
        grant_idx_s = '0;
        for (int i = 0; i < CH; i++) begin
            sel_data_s  = sel_data_s  | (IN_DATA[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
            grant_idx_s = grant_idx_s | (SELW'(i) & {SELW{grant_s[i]}});
        end
    end

    // Output register next state: load wins over drain so a simultaneous
    // drain+load keeps OUT_VALID high with no bubble.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (in_xfer_s) begin
            out_data_d  = sel_data_s;
            out_ch_d    = grant_idx_s;
            out_valid_d = 1'b1;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_DATA  = out_data_q;
    assign OUT_CH    = out_ch_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Testbench for mux_rr_pipe (CH=4, WIDTH=8): table of per-cycle vectors with
// hand-derived IN_READY, and a scoreboard queue of expected output words.
module tb_mux_rr_pipe;

    localparam int CH    = 4;
    localparam int WIDTH = 8;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    mux_rr_pipe #(.CH(CH), .WIDTH(WIDTH)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .MODE      (mode),
        .SEL       (sel),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .OUT_DATA  (out_data),
        .OUT_CH    (out_ch),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        out_ready;
        logic [3:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] ch;
    } word_t;

    vec_t  vecs[$];
    word_t sb[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;

    localparam logic [31:0] DATA_A = 32'hA3A2A1A0;
    localparam logic [31:0] DATA_F = 32'h335A2211;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic void add(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic [31:0] d, input logic ordy, input logic [3:0] er);
        vec_t x;
        x.mode = m; x.sel = s; x.valid = v; x.data = d; x.out_ready = ordy; x.exp_ready = er;
        vecs.push_back(x);
    endfunction

    // Drive one vector mid-cycle, check ready and the held word, then update the model at the edge.
    task automatic apply(input vec_t v, input int idx);
        logic  do_pop;
        logic  do_push;
        word_t w;
        @(negedge clk);
        mode = v.mode; sel = v.sel; in_valid = v.valid; in_data = v.data; out_ready = v.out_ready;
        #1;
        check("in_ready", idx, 32'(in_ready), 32'(v.exp_ready));
        check("out_valid", idx, 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_data", idx, 32'(out_data), 32'(sb[0].d));
            check("out_ch", idx, 32'(out_ch), 32'(sb[0].ch));
        end
        do_pop  = (sb.size() != 0) && v.out_ready;
        do_push = (v.exp_ready != 4'd0);
        w.ch    = onehot_idx(v.exp_ready);
        w.d     = v.data[w.ch*8 +: 8];
        @(posedge clk);
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back(w);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_data = DATA_A; in_valid = 4'hF; out_ready = 1'b0;

        // Reset values with all channels valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 0, 32'(out_valid), 32'd0);
        check("rst_out_data", 0, 32'(out_data), 32'd0);
        check("rst_out_ch", 0, 32'(out_ch), 32'd0);
        check("rst_in_ready", 0, 32'(in_ready), 32'h1);
        in_valid = 4'h0;
        rst_n = 1'b1;

        // First edge after release loads channel 0; then RR fairness over 8 words.
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b0001);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b0010);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b0100);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b1000);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b0001);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b0010);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b0100);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b1000);
        add(1'b0, 2'd0, 4'h0, DATA_A, 1'b1, 4'b0000);
        // Skip and wrap: serve ch2 to put the pointer at 3, then 0,2,0 from 4'b0101.
        add(1'b0, 2'd0, 4'b0100, DATA_A, 1'b1, 4'b0100);
        add(1'b0, 2'd0, 4'b0101, DATA_A, 1'b1, 4'b0001);
        add(1'b0, 2'd0, 4'b0101, DATA_A, 1'b1, 4'b0100);
        add(1'b0, 2'd0, 4'b0101, DATA_A, 1'b1, 4'b0001);
        add(1'b0, 2'd0, 4'h0, DATA_A, 1'b1, 4'b0000);
        // Back-pressure: ch0 loaded (pointer 1), 5 stalled cycles, then drain+load ch1.
        add(1'b0, 2'd0, 4'b0001, DATA_A, 1'b1, 4'b0001);
        for (int i = 0; i < 5; i++) add(1'b0, 2'd0, 4'hF, DATA_A, 1'b0, 4'b0000);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b0010);
        add(1'b0, 2'd0, 4'h0, DATA_A, 1'b1, 4'b0000);
        // Fixed mode: SEL=2 loads 5A; then SEL=2 with ch2 idle never grants.
        add(1'b1, 2'd2, 4'b0100, DATA_F, 1'b1, 4'b0100);
        add(1'b1, 2'd2, 4'b1011, DATA_F, 1'b1, 4'b0000);
        add(1'b1, 2'd2, 4'b1011, DATA_F, 1'b1, 4'b0000);
        add(1'b1, 2'd3, 4'b1011, DATA_F, 1'b1, 4'b1000);
        add(1'b1, 2'd0, 4'b1110, DATA_F, 1'b1, 4'b0000);
        // Word held under back-pressure ahead of the mid-stream reset.
        add(1'b0, 2'd0, 4'b0001, DATA_A, 1'b1, 4'b0001);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b0, 4'b0000);

        n = 0;
        foreach (vecs[i]) begin
            apply(vecs[i], n);
            n++;
        end

        // Mid-stream reset: held word must vanish before any clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", n, 32'(out_valid), 32'd0);
        check("async_rst_out_data", n, 32'(out_data), 32'd0);
        sb.delete();
        in_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // Arbitration restarts from channel 0.
        vecs.delete();
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b0001);
        add(1'b0, 2'd0, 4'hF, DATA_A, 1'b1, 4'b0010);
        add(1'b0, 2'd0, 4'h0, DATA_A, 1'b1, 4'b0000);
        add(1'b0, 2'd0, 4'h0, DATA_A, 1'b1, 4'b0000);
        foreach (vecs[i]) begin
            n++;
            apply(vecs[i], n);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
